// File: rtl/maze_key_pkg.sv
// Shared command codes, keypad constants, FSM encoding and key-to-command map
// for the keypad command sequencer.
package maze_key_pkg;

  localparam logic [2:0] CMD_NONE    = 3'd0;
  localparam logic [2:0] CMD_UP      = 3'd1;
  localparam logic [2:0] CMD_DOWN    = 3'd2;
  localparam logic [2:0] CMD_LEFT    = 3'd3;
  localparam logic [2:0] CMD_RIGHT   = 3'd4;
  localparam logic [2:0] CMD_RESTART = 3'd5;

  localparam logic [3:0] KEY_UP      = 4'd1;
  localparam logic [3:0] KEY_DOWN    = 4'd9;
  localparam logic [3:0] KEY_LEFT    = 4'd4;
  localparam logic [3:0] KEY_RIGHT   = 4'd6;
  localparam logic [3:0] KEY_RESTART = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DEB_PRESS = 2'd1,
    ST_HELD      = 2'd2,
    ST_DEB_REL   = 2'd3
  } key_state_e;

  function automatic logic [2:0] key_to_cmd(input logic [3:0] code);
    case (code)
      KEY_UP:      return CMD_UP;
      KEY_DOWN:    return CMD_DOWN;
      KEY_LEFT:    return CMD_LEFT;
      KEY_RIGHT:   return CMD_RIGHT;
      KEY_RESTART: return CMD_RESTART;
      default:     return CMD_NONE;
    endcase
  endfunction

  // Only the four direction commands auto-repeat.
  function automatic logic cmd_repeats(input logic [2:0] cmd);
    return (cmd >= CMD_UP) && (cmd <= CMD_RIGHT);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Show-ahead command queue; a push while full without a pop is dropped and
// flagged on overflow_o for that cycle.
module cmd_fifo
  import maze_key_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             empty, full, pop, wr_en;

  assign empty      = (wr_q == rd_q);
  assign full       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop        = !empty && ready_i;
  // When full, a simultaneous pop frees the head slot that the write reuses.
  assign wr_en      = push_i && (!full || pop);
  assign overflow_o = push_i && full && !pop;
  assign valid_o    = !empty;
  assign data_o     = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q[AW-1:0]] <= push_data_i;
        wr_q                <= wr_q + PTR_ONE;
      end
      if (pop) rd_q <= rd_q + PTR_ONE;
    end
  end

endmodule

// File: rtl/key_cmd_ctrl.sv
// Keypad command sequencer: sync, 1 ms tick, debounce/auto-repeat FSM and
// command queue towards the maze game logic.
//
// state        | meaning
// IDLE         | no key down
// DEB_PRESS    | key down, waiting for it to be stable
// HELD         | press accepted, auto-repeat running
// DEB_REL      | key up, waiting for the release to be stable
module key_cmd_ctrl
  import maze_key_pkg::*;
#(
  parameter int TICK_DIV        = 50000,
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 150,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_flag,
  input  logic [3:0] key_code,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic       key_held,
  output logic       overflow
);

  localparam int PW    = $clog2(TICK_DIV);
  localparam int TMAX0 = (DEBOUNCE_MS > REPEAT_DELAY_MS) ? DEBOUNCE_MS : REPEAT_DELAY_MS;
  localparam int TMAX  = (TMAX0 > REPEAT_RATE_MS) ? TMAX0 : REPEAT_RATE_MS;
  localparam int TW    = $clog2(TMAX + 1);

  logic          flag_meta_q, flag_sync_q;
  logic [3:0]    code_meta_q, code_sync_q;
  logic [PW-1:0] presc_q;
  logic          tick;
  logic [TW-1:0] timer_q, timer_d, timer_run;
  logic          deb_hit, dly_hit, rate_hit;
  key_state_e    state_q, state_d;
  logic [3:0]    cur_q, cur_d;
  logic          rep_q, rep_d;
  logic          push_req;
  logic [2:0]    cur_cmd;
  logic          fifo_push;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flag_meta_q <= 1'b0;
      flag_sync_q <= 1'b0;
      code_meta_q <= '0;
      code_sync_q <= '0;
      presc_q     <= '0;
    end else begin
      flag_meta_q <= key_flag;
      flag_sync_q <= flag_meta_q;
      code_meta_q <= key_code;
      code_sync_q <= code_meta_q;
      presc_q     <= tick ? '0 : presc_q + 1'b1;
    end
  end

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  // A match fires on the tick that brings the timer up to the target count.
  assign timer_run = !tick ? timer_q : (timer_q == TW'(TMAX)) ? timer_q : timer_q + 1'b1;
  assign deb_hit   = tick && (timer_q == TW'(DEBOUNCE_MS - 1));
  assign dly_hit   = tick && (timer_q == TW'(REPEAT_DELAY_MS - 1));
  assign rate_hit  = tick && (timer_q == TW'(REPEAT_RATE_MS - 1));
  assign cur_cmd   = key_to_cmd(cur_q);

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    rep_d    = rep_q;
    timer_d  = timer_run;
    push_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (flag_sync_q) begin
          cur_d   = code_sync_q;
          state_d = ST_DEB_PRESS;
        end
      end
      ST_DEB_PRESS: begin
        if (!flag_sync_q) begin
          state_d = ST_IDLE;
        end else if (code_sync_q != cur_q) begin
          cur_d   = code_sync_q;
          timer_d = '0;
        end else if (deb_hit) begin
          push_req = 1'b1;
          timer_d  = '0;
          rep_d    = 1'b0;
          state_d  = ST_HELD;
        end
      end
      ST_HELD: begin
        if (!flag_sync_q) begin
          timer_d = '0;
          state_d = ST_DEB_REL;
        end else if (code_sync_q != cur_q) begin
          cur_d   = code_sync_q;
          timer_d = '0;
          state_d = ST_DEB_PRESS;
        end else if (cmd_repeats(cur_cmd)) begin
          if ((!rep_q && dly_hit) || (rep_q && rate_hit)) begin
            push_req = 1'b1;
            rep_d    = 1'b1;
            timer_d  = '0;
          end
        end
      end
      ST_DEB_REL: begin
        if (flag_sync_q && (code_sync_q == cur_q)) begin
          timer_d = '0;
          rep_d   = 1'b1;
          state_d = ST_HELD;
        end else if (flag_sync_q) begin
          cur_d   = code_sync_q;
          timer_d = '0;
          state_d = ST_DEB_PRESS;
        end else if (deb_hit) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      rep_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rep_q   <= rep_d;
      timer_q <= timer_d;
    end
  end

  assign fifo_push = push_req && (cur_cmd != CMD_NONE);
  assign key_held  = (state_q == ST_HELD);

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (3)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (fifo_push),
    .push_data_i (cur_cmd),
    .ready_i     (cmd_ready),
    .valid_o     (cmd_valid),
    .data_o      (cmd_code),
    .overflow_o  (overflow)
  );

endmodule

// File: tb/tb_key_cmd_ctrl.sv
// Directed bench for key_cmd_ctrl with a 4-clk tick and short debounce/repeat
// timings; a negedge monitor logs popped commands and overflow pulses.
module tb_key_cmd_ctrl;
  import maze_key_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_flag = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       cmd_ready = 1'b1;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       key_held;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ovf_cnt = 0;
  int pop_codes[$];
  int pop_cyc[$];

  key_cmd_ctrl #(
    .TICK_DIV        (4),
    .DEBOUNCE_MS     (2),
    .REPEAT_DELAY_MS (5),
    .REPEAT_RATE_MS  (2),
    .FIFO_DEPTH      (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_flag  (key_flag),
    .key_code  (key_code),
    .cmd_ready (cmd_ready),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .key_held  (key_held),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    #2;
    if (reset && cmd_valid && cmd_ready) begin
      pop_codes.push_back(int'(cmd_code));
      pop_cyc.push_back(cyc);
    end
    if (overflow) ovf_cnt++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    pop_codes.delete();
    pop_cyc.delete();
    ovf_cnt = 0;
  endtask

  function automatic int count_code(input int code);
    int n = 0;
    foreach (pop_codes[i]) if (pop_codes[i] == code) n++;
    return n;
  endfunction

  initial begin
    int c0;
    int elapsed;
    bit hit;

    wait_clk(3);
    check("rst_valid", int'(cmd_valid), 0);
    check("rst_code", int'(cmd_code), 0);
    check("rst_held", int'(key_held), 0);
    check("rst_ovf", int'(overflow), 0);
    reset = 1'b1;
    wait_clk(4);

    // Single UP press held 5 ticks.
    clear_log();
    key_code = KEY_UP; key_flag = 1'b1;
    wait_clk(20);
    check("up_held", int'(key_held), 1);
    key_flag = 1'b0;
    wait_clk(5);
    check("up_held_rel", int'(key_held), 0);
    wait_clk(10);
    check("up_idle", int'(dut.state_q), int'(ST_IDLE));
    wait_clk(8);
    check("up_count", pop_codes.size(), 1);
    check("up_code", count_code(1), 1);

    // Bouncing RIGHT key.
    clear_log();
    key_code = KEY_RIGHT; key_flag = 1'b1;
    wait_clk(4);
    key_flag = 1'b0;
    wait_clk(4);
    key_flag = 1'b1;
    c0 = cyc;
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cmd_valid) begin hit = 1; break; end
    end
    elapsed = cyc - c0;
    check("bnc_seen", int'(hit), 1);
    check("bnc_latency_ok", int'(elapsed >= 7 && elapsed <= 12), 1);
    wait_clk(14);
    key_flag = 1'b0;
    wait_clk(16);
    check("bnc_count", pop_codes.size(), 1);
    check("bnc_code", count_code(4), 1);

    // DOWN held 12 ticks: accept plus three repeats.
    clear_log();
    key_code = KEY_DOWN; key_flag = 1'b1;
    wait_clk(48);
    key_flag = 1'b0;
    wait_clk(16);
    check("dn_count", pop_codes.size(), 4);
    check("dn_code", count_code(2), 4);
    if (pop_cyc.size() == 4) begin
      check("dn_gap1", pop_cyc[1] - pop_cyc[0], 20);
      check("dn_gap2", pop_cyc[2] - pop_cyc[1], 8);
      check("dn_gap3", pop_cyc[3] - pop_cyc[2], 8);
    end

    // RESTART never repeats.
    clear_log();
    key_code = KEY_RESTART; key_flag = 1'b1;
    wait_clk(48);
    key_flag = 1'b0;
    wait_clk(16);
    check("rs_count", pop_codes.size(), 1);
    check("rs_code", count_code(5), 1);

    // LEFT held 20 ticks with the consumer stalled.
    clear_log();
    cmd_ready = 1'b0;
    key_code = KEY_LEFT; key_flag = 1'b1;
    wait_clk(80);
    key_flag = 1'b0;
    wait_clk(16);
    check("ovf_pulses", ovf_cnt, 4);
    check("ovf_valid", int'(cmd_valid), 1);
    check("ovf_nopop", pop_codes.size(), 0);
    cmd_ready = 1'b1;
    wait_clk(10);
    check("drain_count", pop_codes.size(), 4);
    check("drain_code", count_code(3), 4);
    check("drain_empty", int'(cmd_valid), 0);

    // Push and pop in the same cycle while full.
    clear_log();
    cmd_ready = 1'b0;
    key_code = KEY_LEFT; key_flag = 1'b1;
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dut.fifo_push && dut.u_fifo.full) begin
        cmd_ready = 1'b1;
        #1;
        check("pp_no_ovf", int'(overflow), 0);
        hit = 1;
        break;
      end
    end
    check("pp_found", int'(hit), 1);
    @(negedge clk);
    cmd_ready = 1'b0;
    key_flag = 1'b0;
    wait_clk(16);
    check("pp_full", int'(dut.u_fifo.full), 1);
    check("pp_ovf_total", ovf_cnt, 0);
    check("pp_one_pop", pop_codes.size(), 1);
    cmd_ready = 1'b1;
    wait_clk(10);
    check("pp_total", pop_codes.size(), 5);
    check("pp_code", count_code(3), 5);

    // Unmapped key 2: held but silent.
    clear_log();
    key_code = 4'd2; key_flag = 1'b1;
    wait_clk(16);
    check("k2_held", int'(key_held), 1);
    check("k2_novalid", int'(cmd_valid), 0);
    key_flag = 1'b0;
    wait_clk(16);
    check("k2_count", pop_codes.size(), 0);

    // Reset with 3 queued commands while HELD.
    clear_log();
    cmd_ready = 1'b0;
    key_code = KEY_DOWN; key_flag = 1'b1;
    wait_clk(40);
    check("rq_held", int'(key_held), 1);
    check("rq_valid", int'(cmd_valid), 1);
    reset = 1'b0;
    #1;
    check("rq_rst_valid", int'(cmd_valid), 0);
    check("rq_rst_held", int'(key_held), 0);
    wait_clk(2);
    key_flag = 1'b0;
    wait_clk(2);
    reset = 1'b1;
    cmd_ready = 1'b1;
    clear_log();
    wait_clk(40);
    check("rq_no_stale", pop_codes.size(), 0);
    check("rq_valid_after", int'(cmd_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
